// File: rtl/wishbone_ram_32_controller.sv
// wishbone_ram_32_controller: Wishbone B3 slave front-end for a 32-bit RAM of four 8-bit slices; WB_RAM_BURST_EN enables linear read bursts
module wishbone_ram_32_controller #(
  parameter int ADDR_WIDTH = 11,
  parameter int WB_AW      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [WB_AW-1:0]      wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [2:0]            wb_cti_i,
  input  logic [1:0]            wb_bte_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [3:0]            ram_we_o,
  output logic [31:0]           ram_data_o,
  input  logic [31:0]           ram_data_i
);
`ifdef WB_RAM_BURST_EN
  typedef enum logic [1:0] {IDLE, RESP, BURST} state_t;
  logic [ADDR_WIDTH-1:0] burst_addr_q, burst_addr_d, burst_next;
`else
  typedef enum logic {IDLE, RESP} state_t;
`endif
  state_t state_q, state_d;
  logic ack_q, ack_d, err_q, err_d, rd_q, rd_d;
  logic req, in_range, rd_ack, unused_ok;
  logic [ADDR_WIDTH-1:0] word_addr;
  assign req        = wb_cyc_i & wb_stb_i;
  assign word_addr  = wb_adr_i[ADDR_WIDTH+1:2];
  assign in_range   = ~|wb_adr_i[WB_AW-1:ADDR_WIDTH+2];
  assign ram_data_o = wb_dat_i;
  assign wb_dat_o   = rd_ack ? ram_data_i : '0;
  assign unused_ok  = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0]};
`ifdef WB_RAM_BURST_EN
  assign burst_next = burst_addr_q + 1'b1;
`endif
  // reset masks the outputs combinationally so a reset in RESP suppresses the pending ack
  always_comb begin
    state_d    = IDLE;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rd_d       = 1'b0;
    ram_addr_o = word_addr;
    ram_we_o   = '0;
    wb_ack_o   = 1'b0;
    wb_err_o   = 1'b0;
    rd_ack     = 1'b0;
`ifdef WB_RAM_BURST_EN
    burst_addr_d = burst_addr_q;
`endif
    if (!rst_i) begin
      wb_ack_o = ack_q;
      wb_err_o = err_q;
      rd_ack   = ack_q & rd_q;
      case (state_q)
        IDLE: if (req) begin
          state_d  = RESP;
          ack_d    = in_range;
          err_d    = ~in_range;
          rd_d     = ~wb_we_i;
          ram_we_o = (in_range & wb_we_i) ? wb_sel_i : '0;
`ifdef WB_RAM_BURST_EN
          if (in_range && !wb_we_i && wb_cti_i == 3'b010 && wb_bte_i == 2'b00) begin
            state_d      = BURST;
            ack_d        = 1'b0;
            burst_addr_d = word_addr;
          end
`endif
        end
        RESP: state_d = IDLE;
`ifdef WB_RAM_BURST_EN
        // prefetch the next word on every ack so one beat completes per cycle
        BURST: begin
          wb_ack_o     = req;
          rd_ack       = req;
          ram_addr_o   = req ? burst_next : burst_addr_q;
          burst_addr_d = req ? burst_next : burst_addr_q;
          state_d      = (!wb_cyc_i || (req && wb_cti_i == 3'b111)) ? IDLE : BURST;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end
`ifdef WB_RAM_BURST_EN
  always_ff @(posedge clk_i) begin
    burst_addr_q <= burst_addr_d;
  end
`endif
endmodule
